nec_ir_tx: RTL and testbench
============================

Name: nec_ir_tx

Overview:
NEC infrared transmitter. It is the sending end of the NEC link whose receive side we decode. It accepts an address/command byte pair, or a repeat request, through a single-cycle valid handshake when idle. It then emits a complete NEC frame as a pulse-distance envelope and as a 38 kHz-modulated drive for the IR LED. It sits behind the UART command path: a byte pair received over UART is handed to this block for transmission.

Parameters:
TICK_CYCLES, 28125, clk cycles per NEC unit of 562.5 us (50 MHz clock).
CARRIER_HALF, 658, clk cycles per carrier half-period (about 38 kHz at 50 MHz).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
i_valid  input  1  request strobe; sampled only when o_busy=0
i_addr  input  8  NEC address byte
i_cmd  input  8  NEC command byte
i_repeat  input  1  with i_valid: send a repeat frame (i_addr and i_cmd ignored)
o_busy  output  1  high from the cycle after acceptance until the frame ends
o_done  output  1  one-cycle pulse at frame end
o_ir_env  output  1  unmodulated envelope, 1 = mark
o_ir_tx  output  1  modulated LED drive, equal to o_ir_env AND carrier

Behaviour:
- Reset, asynchronous and active-low, takes effect immediately, including mid-frame:
  - state=IDLE
  - o_busy, o_done, o_ir_env and o_ir_tx are all 0
  - unit counter, carrier counter and bit index are cleared
- Acceptance: on a clk edge with state=IDLE and i_valid=1:
  - latch word = {~i_cmd, i_cmd, ~i_addr, i_addr} and the repeat flag
  - next cycle: o_busy=1 and o_ir_env=1 (LEAD_MARK)
  - i_valid while busy is ignored, with no queueing
- Durations are whole units; one unit = TICK_CYCLES cycles, counted by a tick counter.
- Normal frame states:
  - LEAD_MARK: 16 units, mark
  - LEAD_SPACE: 8 units, space
  - BIT_MARK: 1 unit, mark
  - BIT_SPACE: 1 unit if word[i]=0, 3 units if word[i]=1, space
  - BIT_MARK/BIT_SPACE repeat for i=0..31, LSB of word first
  - STOP_MARK: 1 unit, mark
  - then IDLE
- Repeat frame states: LEAD_MARK 16 units, REP_SPACE 4 units, STOP_MARK 1 unit, IDLE.
- Frame lengths:
  - Every normal frame has exactly 16 ones and 16 zeros, so o_busy lasts 121*TICK_CYCLES cycles regardless of data.
  - A repeat frame lasts 21*TICK_CYCLES cycles.
- End of frame, in the cycle after the last STOP_MARK cycle:
  - o_busy=0, o_ir_env=0, o_done=1 for exactly one cycle
  - i_valid is accepted in that same cycle, giving back-to-back frames with a 1-cycle gap
- Carrier:
  - counter reloads at the first cycle of every mark, with phase=1
  - phase toggles every CARRIER_HALF cycles while in a mark
  - o_ir_tx=0 whenever o_ir_env=0
  - o_ir_tx is registered and aligned with o_ir_env, with no glitches
- State/envelope changes occur only on unit boundaries. Counters are wide enough for TICK_CYCLES*16 without wrap.

Test Plan:
Run all scenarios with TICK_CYCLES=4 and CARRIER_HALF=1.
1. i_valid with addr=0x00, cmd=0x16 -> o_busy high 484 cycles; envelope gives leader 64 mark/32 space; bits 0-7 each 4 mark/4 space; bits 8-15 each 4 mark/12 space; bits 16-31 follow 0x16 then 0xE9 LSB first; 4-cycle stop mark; then o_done pulses once.
2. i_valid with i_repeat=1 -> o_busy 84 cycles; envelope 64 mark, 16 space, 4 mark; o_done pulses; i_addr/i_cmd values do not matter.
3. o_ir_tx during any mark alternates 1,0,1,0 starting at 1 on the first mark cycle; o_ir_tx=0 on every space cycle.
4. i_valid pulsed at cycle 100 of a frame with different data -> ignored; frame unchanged; exactly one o_done.
5. i_valid held high continuously -> frames back-to-back, each 484 cycles busy, a 1-cycle gap with o_done=1, second frame carries the new data.
6. rst asserted mid-BIT_SPACE then released -> all outputs 0 asynchronously; no o_done; a new i_valid starts a clean full frame.

Source files
------------

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter.
// Accepts an address/command pair or a repeat request while idle. It then
// emits one NEC frame two ways: as a pulse-distance envelope (o_ir_env), and
// as the same envelope gated by a 38 kHz carrier (o_ir_tx) to drive the LED.
// All outputs are registered. State and envelope change only on unit edges.
module nec_ir_tx #(
  parameter int TICK_CYCLES  = 28125,  // clk cycles per 562.5 us NEC unit
  parameter int CARRIER_HALF = 658     // clk cycles per carrier half-period
) (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active-low
  input  logic       i_valid,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_cmd,
  input  logic       i_repeat,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ir_env,
  output logic       o_ir_tx
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int CW = $clog2(CARRIER_HALF + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_REP_SPACE,
    S_STOP_MARK
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;    // cycle position inside the current unit
  logic [4:0]      units_left;  // units still to run in the current state
  logic [CW-1:0]   car_cnt;     // cycle position inside a carrier half-period
  logic [4:0]      bit_idx;     // word bit being sent, LSB first
  logic [31:0]     word;        // {~cmd, cmd, ~addr, addr}
  logic            rep;         // latched repeat request

  logic unit_end;
  logic last_unit;
  logic car_wrap;

  assign unit_end  = (tick_cnt == TICK_LAST);
  assign last_unit = (units_left == 5'd1);
  assign car_wrap  = (car_cnt == CAR_LAST);

  // Frame sequencer, unit timer, carrier generator and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values. A later assignment to the same register in this
  // block (e.g. reloading the carrier when a mark begins) overrides an earlier
  // one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      units_left <= '0;
      car_cnt    <= '0;
      bit_idx    <= '0;
      word       <= '0;
      rep        <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_ir_env   <= 1'b0;
      o_ir_tx    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            word       <= {~i_cmd, i_cmd, ~i_addr, i_addr};
            rep        <= i_repeat;
            state      <= S_LEAD_MARK;
            units_left <= 5'd16;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            car_cnt    <= '0;
            o_busy     <= 1'b1;
            o_ir_env   <= 1'b1;
            o_ir_tx    <= 1'b1;
          end
        end

        default: begin
          // The carrier runs freely for the whole of a mark, across unit edges.
          if (o_ir_env) begin
            if (car_wrap) begin
              car_cnt <= '0;
              o_ir_tx <= ~o_ir_tx;
            end else begin
              car_cnt <= car_cnt + CW'(1);
            end
          end

          if (!unit_end) begin
            tick_cnt <= tick_cnt + TW'(1);
          end else begin
            tick_cnt <= '0;
            if (!last_unit) begin
              units_left <= units_left - 5'd1;
            end else begin
              case (state)
                S_LEAD_MARK: begin
                  state      <= rep ? S_REP_SPACE : S_LEAD_SPACE;
                  units_left <= rep ? 5'd4 : 5'd8;
                  o_ir_env   <= 1'b0;
                  o_ir_tx    <= 1'b0;
                end
                S_LEAD_SPACE: begin
                  state      <= S_BIT_MARK;
                  units_left <= 5'd1;
                  car_cnt    <= '0;
                  o_ir_env   <= 1'b1;
                  o_ir_tx    <= 1'b1;
                end
                S_BIT_MARK: begin
                  // A '1' is a long space, a '0' is a short one.
                  state      <= S_BIT_SPACE;
                  units_left <= word[bit_idx] ? 5'd3 : 5'd1;
                  o_ir_env   <= 1'b0;
                  o_ir_tx    <= 1'b0;
                end
                S_BIT_SPACE: begin
                  if (bit_idx == 5'd31) begin
                    state <= S_STOP_MARK;
                  end else begin
                    state   <= S_BIT_MARK;
                    bit_idx <= bit_idx + 5'd1;
                  end
                  units_left <= 5'd1;
                  car_cnt    <= '0;
                  o_ir_env   <= 1'b1;
                  o_ir_tx    <= 1'b1;
                end
                S_REP_SPACE: begin
                  state      <= S_STOP_MARK;
                  units_left <= 5'd1;
                  car_cnt    <= '0;
                  o_ir_env   <= 1'b1;
                  o_ir_tx    <= 1'b1;
                end
                S_STOP_MARK: begin
                  state    <= S_IDLE;
                  o_busy   <= 1'b0;
                  o_done   <= 1'b1;
                  o_ir_env <= 1'b0;
                  o_ir_tx  <= 1'b0;
                end
                default: begin
                  state    <= S_IDLE;
                  o_busy   <= 1'b0;
                  o_ir_env <= 1'b0;
                  o_ir_tx  <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Self-checking bench for nec_ir_tx with short units (4 cycles) and the
// fastest carrier (1-cycle half-period). The expected waveform of every frame
// is built from the NEC segment rules: a list of (mark/space, units) pairs
// expanded to cycles.
module tb_nec_ir_tx;

  localparam int T  = 4;
  localparam int CH = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_addr = 8'h00;
  logic [7:0] i_cmd = 8'h00;
  logic       i_repeat = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic       o_ir_env;
  logic       o_ir_tx;

  int checks = 0;
  int errors = 0;

  bit exp_env[$];
  bit exp_tx[$];

  typedef struct {
    bit         rep;
    logic [7:0] addr;
    logic [7:0] cmd;
    int         busy_len;
  } vec_t;

  nec_ir_tx #(.TICK_CYCLES(T), .CARRIER_HALF(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_addr   (i_addr),
    .i_cmd    (i_cmd),
    .i_repeat (i_repeat),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ir_env (o_ir_env),
    .o_ir_tx  (o_ir_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle envelope and LED drive for one frame, from the rules.
  task automatic build_model(input bit rep, input logic [7:0] a, input logic [7:0] c);
    bit          seg_mark[$];
    int          seg_units[$];
    logic [31:0] w;
    w = {~c, c, ~a, a};
    seg_mark.push_back(1'b1); seg_units.push_back(16);
    if (rep) begin
      seg_mark.push_back(1'b0); seg_units.push_back(4);
    end else begin
      seg_mark.push_back(1'b0); seg_units.push_back(8);
      for (int i = 0; i < 32; i++) begin
        seg_mark.push_back(1'b1); seg_units.push_back(1);
        seg_mark.push_back(1'b0); seg_units.push_back(w[i] ? 3 : 1);
      end
    end
    seg_mark.push_back(1'b1); seg_units.push_back(1);
    exp_env.delete();
    exp_tx.delete();
    for (int s = 0; s < seg_mark.size(); s++) begin
      for (int k = 0; k < seg_units[s] * T; k++) begin
        exp_env.push_back(seg_mark[s]);
        exp_tx.push_back(seg_mark[s] && ((k / CH) % 2 == 0));
      end
    end
  endtask

  // Request a frame; returns at the negedge of the first busy cycle.
  task automatic start_frame(input bit rep, input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    i_valid  = 1'b1;
    i_repeat = rep;
    i_addr   = a;
    i_cmd    = c;
    @(negedge clk);
    i_valid  = 1'b0;
  endtask

  // Compare a running frame cycle by cycle, then its length and the done
  // cycle. Optionally pulse a conflicting request at frame cycle poke_at.
  // Returns at the negedge of the o_done cycle.
  task automatic check_frame(input bit rep, input logic [7:0] a, input logic [7:0] c,
                             input int exp_len, input string tag, input int poke_at);
    int cnt;
    build_model(rep, a, c);
    cnt = 0;
    while (o_busy === 1'b1 && cnt < 1000) begin
      bit e_env;
      bit e_tx;
      e_env = (cnt < exp_env.size()) ? exp_env[cnt] : 1'b0;
      e_tx  = (cnt < exp_tx.size()) ? exp_tx[cnt] : 1'b0;
      check($sformatf("%s wave@%0d {busy,done,env,tx}", tag, cnt),
            {28'd0, o_busy, o_done, o_ir_env, o_ir_tx},
            {28'd0, 1'b1, 1'b0, e_env, e_tx});
      if (cnt == poke_at) begin
        i_valid  = 1'b1;
        i_addr   = ~a;
        i_cmd    = c ^ 8'h5A;
        i_repeat = ~rep;
      end else if (poke_at >= 0 && cnt == poke_at + 1) begin
        i_valid = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    check({tag, " busy_len"}, cnt, exp_len);
    check({tag, " end {busy,done,env,tx}"},
          {28'd0, o_busy, o_done, o_ir_env, o_ir_tx}, 32'b0100);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {28'd0, o_busy, o_done, o_ir_env, o_ir_tx}, 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;

    vecs.push_back('{rep: 1'b0, addr: 8'h00, cmd: 8'h16, busy_len: 121 * T});
    vecs.push_back('{rep: 1'b1, addr: 8'hAA, cmd: 8'h55, busy_len: 21 * T});
    vecs.push_back('{rep: 1'b0, addr: 8'hFF, cmd: 8'hFF, busy_len: 121 * T});
    vecs.push_back('{rep: 1'b0, addr: 8'h5A, cmd: 8'hC3, busy_len: 121 * T});
    vecs.push_back('{rep: 1'b1, addr: 8'h00, cmd: 8'h00, busy_len: 21 * T});
    for (int r = 0; r < 4; r++) begin
      v.rep      = ($urandom_range(0, 3) == 0);
      v.addr     = 8'($urandom);
      v.cmd      = 8'($urandom);
      v.busy_len = v.rep ? 21 * T : 121 * T;
      vecs.push_back(v);
    end

    // Reset state, while held and just after release.
    repeat (3) @(negedge clk);
    check_quiet("in reset");
    rst = 1'b1;
    @(negedge clk);
    check_quiet("idle after reset");

    // Table of frames: normal, repeat, extremes, random.
    for (int i = 0; i < vecs.size(); i++) begin
      start_frame(vecs[i].rep, vecs[i].addr, vecs[i].cmd);
      check_frame(vecs[i].rep, vecs[i].addr, vecs[i].cmd, vecs[i].busy_len,
                  $sformatf("vec%0d", i), -1);
      @(negedge clk);
      check_quiet($sformatf("vec%0d done once", i));
    end

    // A request pulsed mid-frame is ignored.
    start_frame(1'b0, 8'h12, 8'h34);
    check_frame(1'b0, 8'h12, 8'h34, 121 * T, "ignore", 100);
    @(negedge clk);
    check_quiet("ignore done once");

    // i_valid held high: back-to-back frames, second one carrying new data.
    @(negedge clk);
    i_valid = 1'b1; i_repeat = 1'b0; i_addr = 8'h81; i_cmd = 8'h0F;
    @(negedge clk);
    check_frame(1'b0, 8'h81, 8'h0F, 121 * T, "b2b first", -1);
    i_addr = 8'h3E; i_cmd = 8'hD2;
    @(negedge clk);
    check_frame(1'b0, 8'h3E, 8'hD2, 121 * T, "b2b second", -1);
    i_valid = 1'b0;
    @(negedge clk);
    check_quiet("b2b stop");

    // Reset in the middle of the bit-0 space, then a clean frame.
    build_model(1'b0, 8'h3C, 8'hA5);
    start_frame(1'b0, 8'h3C, 8'hA5);
    repeat (101) @(negedge clk);
    check("pre-reset env", {31'd0, o_ir_env}, {31'd0, exp_env[101]});
    #2 rst = 1'b0;
    #1 check_quiet("async reset");
    @(negedge clk);
    check_quiet("held reset 1");
    @(negedge clk);
    check_quiet("held reset 2");
    rst = 1'b1;
    @(negedge clk);
    check_quiet("after reset release");
    start_frame(1'b0, 8'hC7, 8'h29);
    check_frame(1'b0, 8'hC7, 8'h29, 121 * T, "post-reset", -1);
    @(negedge clk);
    check_quiet("post-reset done once");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
